alu_arbiter: RTL and testbench

Shares the single 8-bit ALU between two independent requesters. Each requester issues commands (opcode plus two operands) over a valid/ready handshake. The block arbitrates round-robin, drives the ALU operand/opcode inputs for one execute cycle, and captures result and flags. It returns them to the owning requester through a one-entry response slot with its own valid/ready handshake. It sits between the instruction front-ends and the ALU instance.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_arbiter_rr_arb2.sv | 40 ++++
 rtl/alu_arbiter.sv | 164 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, flag bit
// positions, FSM encoding and the illegal-opcode check.
package alu_pkg;

    localparam int unsigned OPC_W = 3;
    localparam int unsigned FLG_W = 4;

    localparam logic [OPC_W-1:0] OP_ADD = 3'b000;
    localparam logic [OPC_W-1:0] OP_SUB = 3'b001;
    localparam logic [OPC_W-1:0] OP_AND = 3'b100;
    localparam logic [OPC_W-1:0] OP_OR  = 3'b101;
    localparam logic [OPC_W-1:0] OP_XOR = 3'b110;
    localparam logic [OPC_W-1:0] OP_NOT = 3'b111;

    localparam int unsigned FLG_C = 3;
    localparam int unsigned FLG_Z = 2;
    localparam int unsigned FLG_V = 1;
    localparam int unsigned FLG_N = 0;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

    // 010 and 011 have no ALU operation behind them
    function automatic logic is_illegal(input logic [OPC_W-1:0] op);
        return (op == 3'b010) || (op == 3'b011);
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; on a tie the requester that did not win
// last time gets the grant. last_grant only moves on an advance strobe.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] elig,
    input  logic       advance,
    output logic [1:0] grant_c
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        grant_c = 2'b00;
        unique case (elig)
            2'b01:   grant_c = 2'b01;
            2'b10:   grant_c = 2'b10;
            2'b11:   grant_c = last_grant_q ? 2'b01 : 2'b10;
            default: grant_c = 2'b00;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (advance && (grant_c != 2'b00)) begin
            last_grant_d = grant_c[1];
        end
    end

    // Reset to 1 so requester 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: round-robin grant, one
// execute cycle, result returned through a per-requester one-entry slot.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OPC_W-1:0]  req0_opcode,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OPC_W-1:0]  req1_opcode,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic [FLG_W-1:0]  rsp0_flags,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic [FLG_W-1:0]  rsp1_flags,
    output logic              rsp1_err,
    output logic [OPC_W-1:0]  alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    input  logic              alu_negative,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    state_e                       state_q, state_d;
    logic                         owner_q, owner_d;
    logic [OPC_W-1:0]             opc_q, opc_d;
    logic [DATA_W-1:0]            a_q, a_d;
    logic [DATA_W-1:0]            b_q, b_d;
    logic [1:0]                   rsp_valid_q, rsp_valid_d;
    logic [1:0][DATA_W-1:0]       rsp_result_q, rsp_result_d;
    logic [1:0][FLG_W-1:0]        rsp_flags_q, rsp_flags_d;
    logic [1:0]                   rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]             op_count_q, op_count_d;

    logic [1:0] elig_c;
    logic [1:0] grant_c;
    logic [1:0] rsp_ready_c;
    logic       advance_c;

    // A full response slot blocks only its own requester
    assign elig_c      = {req1_valid & ~rsp_valid_q[1], req0_valid & ~rsp_valid_q[0]};
    assign rsp_ready_c = {rsp1_ready, rsp0_ready};
    assign advance_c   = (state_q == IDLE);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .elig    (elig_c),
        .advance (advance_c),
        .grant_c (grant_c)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        opc_d        = opc_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;
        op_count_d   = op_count_q;

        for (int i = 0; i < 2; i++) begin
            if (rsp_valid_q[i] && rsp_ready_c[i]) begin
                rsp_valid_d[i] = 1'b0;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (grant_c != 2'b00) begin
                    state_d = EXEC;
                    owner_d = grant_c[1];
                    opc_d   = grant_c[1] ? req1_opcode : req0_opcode;
                    a_d     = grant_c[1] ? req1_a      : req0_a;
                    b_d     = grant_c[1] ? req1_b      : req0_b;
                end
            end
            EXEC: begin
                state_d              = IDLE;
                rsp_valid_d[owner_q] = 1'b1;
                op_count_d           = op_count_q + CNT_W'(1);
                if (is_illegal(opc_q)) begin
                    rsp_result_d[owner_q] = '0;
                    rsp_flags_d[owner_q]  = '0;
                    rsp_err_d[owner_q]    = 1'b1;
                end else begin
                    rsp_result_d[owner_q]        = alu_result;
                    rsp_flags_d[owner_q][FLG_C]  = alu_carry;
                    rsp_flags_d[owner_q][FLG_Z]  = alu_zero;
                    rsp_flags_d[owner_q][FLG_V]  = alu_overflow;
                    rsp_flags_d[owner_q][FLG_N]  = alu_negative;
                    rsp_err_d[owner_q]           = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            opc_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= '0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            opc_q        <= opc_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
            op_count_q   <= op_count_d;
        end
    end

    // Operand registers feed the ALU directly and keep their value in IDLE
    assign alu_opcode  = opc_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign busy        = (state_q == EXEC);
    assign op_count    = op_count_q;
    assign req0_ready  = (state_q == IDLE) & grant_c[0];
    assign req1_ready  = (state_q == IDLE) & grant_c[1];
    assign rsp0_valid  = rsp_valid_q[0];
    assign rsp0_result = rsp_result_q[0];
    assign rsp0_flags  = rsp_flags_q[0];
    assign rsp0_err    = rsp_err_q[0];
    assign rsp1_valid  = rsp_valid_q[1];
    assign rsp1_result = rsp_result_q[1];
    assign rsp1_flags  = rsp_flags_q[1];
    assign rsp1_err    = rsp_err_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU and a per-requester
// scoreboard of expected {result, flags, err} responses.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]        req0_opcode, req1_opcode;
    logic [7:0]        req0_a, req0_b, req1_a, req1_b;
    logic              rsp0_valid, rsp0_ready, rsp0_err, rsp1_valid, rsp1_ready, rsp1_err;
    logic [7:0]        rsp0_result, rsp1_result;
    logic [3:0]        rsp0_flags, rsp1_flags;
    logic [2:0]        alu_opcode;
    logic [7:0]        alu_a, alu_b, alu_result;
    logic              alu_carry, alu_zero, alu_overflow, alu_negative;
    logic              busy;
    logic [CNT_W-1:0]  op_count;

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;

    logic [12:0] exp_q [2][$];
    int          grant_log [$];
    int          acc_cyc [2];
    int          n_rsp [2];
    logic [1:0]  prev_v, prev_rdy;
    logic [12:0] prev_rsp [2];
    logic [12:0] got [2];
    logic [1:0]  hs_req, rv, rr;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_flags(rsp0_flags), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_flags(rsp1_flags), .rsp1_err(rsp1_err),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .alu_negative(alu_negative),
        .busy(busy), .op_count(op_count)
    );

    // Behavioural ALU: returns {result, carry, zero, overflow, negative}
    function automatic logic [11:0] alu_ref(input logic [2:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] r;
        logic       c, v;
        s = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            3'b000: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8];
                          v = (a[7] == b[7]) && (r[7] != a[7]); end
            3'b001: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8];
                          v = (a[7] != b[7]) && (r[7] != a[7]); end
            3'b100: r = a & b;
            3'b101: r = a | b;
            3'b110: r = a ^ b;
            3'b111: r = ~a;
            default: begin r = 8'hA5; c = 1'b1; v = 1'b1; end
        endcase
        return {r, c, (r == 8'h00), v, r[7]};
    endfunction

    function automatic logic [12:0] exp_of(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        if (op == 3'b010 || op == 3'b011) return 13'h0001;
        return {alu_ref(op, a, b), 1'b0};
    endfunction

    always_comb {alu_result, alu_carry, alu_zero, alu_overflow, alu_negative} =
        alu_ref(alu_opcode, alu_a, alu_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        hs_req = {req1_valid & req1_ready, req0_valid & req0_ready};
        rv     = {rsp1_valid, rsp0_valid};
        rr     = {rsp1_ready, rsp0_ready};
        got[0] = {rsp0_result, rsp0_flags, rsp0_err};
        got[1] = {rsp1_result, rsp1_flags, rsp1_err};
        if (!rst_n) begin
            prev_v   = '0;
            prev_rdy = '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (hs_req[i]) begin
                    if (i == 0) exp_q[0].push_back(exp_of(req0_opcode, req0_a, req0_b));
                    else        exp_q[1].push_back(exp_of(req1_opcode, req1_a, req1_b));
                    acc_cyc[i] = cyc;
                    grant_log.push_back(i);
                end
                if (rv[i] && !prev_v[i]) begin
                    chk("rsp_latency", 32'(cyc - acc_cyc[i]), 32'd2);
                    chk("rsp_outstanding", 32'(exp_q[i].size()), 32'd1);
                    if (exp_q[i].size() > 0) chk("rsp_data", 32'(got[i]), 32'(exp_q[i][0]));
                end
                if (rv[i] && prev_v[i] && !prev_rdy[i])
                    chk("rsp_hold", 32'(got[i]), 32'(prev_rsp[i]));
                if (rv[i] && rr[i] && exp_q[i].size() > 0) begin
                    void'(exp_q[i].pop_front());
                    n_rsp[i]++;
                end
                prev_rsp[i] = got[i];
            end
            prev_v   = rv;
            prev_rdy = rr;
        end
    end

    initial begin
        logic [12:0]      held;
        int               start1;
        logic [CNT_W-1:0] cnt0;

        req0_valid = 0; req0_opcode = '0; req0_a = '0; req0_b = '0;
        req1_valid = 0; req1_opcode = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 0; rsp1_ready = 0;
        n_rsp[0] = 0; n_rsp[1] = 0; acc_cyc[0] = 0; acc_cyc[1] = 0;
        step(2);
        chk("reset_rsp", 32'({rsp1_valid, rsp0_valid, rsp0_result, rsp0_flags, rsp0_err,
                              rsp1_result, rsp1_flags, rsp1_err}), 32'd0);
        chk("reset_alu", 32'({alu_opcode, alu_a, alu_b}), 32'd0);
        chk("reset_busy_cnt", 32'({busy, op_count}), 32'd0);
        rst_n = 1'b1;
        step(1);

        // ADD overflow into sign bit
        rsp0_ready = 1; rsp1_ready = 1;
        req0_valid = 1; req0_opcode = OP_ADD; req0_a = 8'h7F; req0_b = 8'h01;
        #1 chk("t1_ready", 32'(req0_ready), 32'd1);
        step(1);
        req0_valid = 0;
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_alu_drive", 32'({alu_opcode, alu_a, alu_b}), 32'({OP_ADD, 8'h7F, 8'h01}));
        chk("t1_ready_exec", 32'(req0_ready), 32'd0);
        step(1);
        chk("t1_valid", 32'(rsp0_valid), 32'd1);
        chk("t1_result", 32'(rsp0_result), 32'h80);
        chk("t1_flags", 32'(rsp0_flags), 32'b0011);
        chk("t1_err", 32'(rsp0_err), 32'd0);
        chk("t1_op_count", 32'(op_count), 32'd1);
        chk("t1_busy_idle", 32'(busy), 32'd0);
        step(1);
        chk("t1_alu_hold", 32'(alu_a), 32'h7F);
        chk("t1_drained", 32'(rsp0_valid), 32'd0);

        // Continuous streams from a fresh reset: grants must alternate 0,1,0,...
        rst_n = 0; #2 rst_n = 1;
        exp_q[0].delete(); exp_q[1].delete(); grant_log.delete();
        step(1);
        req0_valid = 1; req0_opcode = OP_XOR; req0_a = 8'hF0; req0_b = 8'h0F;
        req1_valid = 1; req1_opcode = OP_AND; req1_a = 8'hF0; req1_b = 8'h0F;
        step(14);
        req0_valid = 0; req1_valid = 0;
        step(6);
        chk("t2_ngrant", 32'(grant_log.size()), 32'd7);
        for (int k = 0; k < grant_log.size(); k++)
            chk("t2_grant_order", 32'(grant_log[k]), 32'(k % 2));

        // Full slot 0 blocks requester 0 only
        rsp0_ready = 0; rsp1_ready = 1;
        req0_valid = 1; req0_opcode = OP_ADD; req0_a = 8'h01; req0_b = 8'h02;
        req1_valid = 1; req1_opcode = OP_OR;  req1_a = 8'h30; req1_b = 8'h03;
        for (int k = 0; k < 10 && !rsp0_valid; k++) step(1);
        chk("t3_rsp0_full", 32'(rsp0_valid), 32'd1);
        held   = {rsp0_result, rsp0_flags, rsp0_err};
        start1 = n_rsp[1];
        for (int k = 0; k < 8; k++) begin
            chk("t3_req0_blocked", 32'(req0_ready), 32'd0);
            step(1);
        end
        chk("t3_rsp0_stable", 32'({rsp0_result, rsp0_flags, rsp0_err}), 32'(held));
        chk("t3_req1_progress", 32'(n_rsp[1] - start1 >= 2), 32'd1);
        req1_valid = 0;
        step(4);
        rsp0_ready = 1;
        #1 chk("t3_no_bypass", 32'(req0_ready), 32'd0);
        step(1);
        chk("t3_drained", 32'(rsp0_valid), 32'd0);
        chk("t3_regrant", 32'(req0_ready), 32'd1);
        step(1);
        req0_valid = 0;
        step(4);

        // Illegal opcode on requester 1
        cnt0 = op_count;
        req1_valid = 1; req1_opcode = 3'b010; req1_a = 8'h12; req1_b = 8'h34;
        step(1);
        req1_valid = 0;
        step(1);
        chk("t4_valid", 32'(rsp1_valid), 32'd1);
        chk("t4_rsp", 32'({rsp1_result, rsp1_flags, rsp1_err}), 32'h0001);
        chk("t4_op_count", 32'(op_count), 32'(CNT_W'(cnt0 + CNT_W'(1))));
        step(2);

        // SUB to zero, then NOT
        req0_valid = 1; req0_opcode = OP_SUB; req0_a = 8'h05; req0_b = 8'h05;
        step(1); req0_valid = 0; step(1);
        chk("t5_sub", 32'({rsp0_result, rsp0_flags, rsp0_err}), 32'({8'h00, 4'b0100, 1'b0}));
        step(2);
        req0_valid = 1; req0_opcode = OP_NOT; req0_a = 8'h0F; req0_b = 8'hAA;
        step(1); req0_valid = 0; step(1);
        chk("t5_not", 32'({rsp0_result, rsp0_flags, rsp0_err}), 32'({8'hF0, 4'b0001, 1'b0}));
        step(2);

        // Asynchronous reset in the middle of EXEC
        req0_valid = 1; req0_opcode = OP_ADD; req0_a = 8'h10; req0_b = 8'h20;
        step(1);
        req0_valid = 0;
        chk("t6_in_exec", 32'(busy), 32'd1);
        #2 rst_n = 0;
        #1 chk("t6_async_clear", 32'({rsp1_valid, rsp0_valid, busy, op_count}), 32'd0);
        exp_q[0].delete(); exp_q[1].delete();
        step(1);
        rst_n = 1;
        step(4);
        chk("t6_no_rsp", 32'({rsp1_valid, rsp0_valid}), 32'd0);
        req0_valid = 1; req0_opcode = OP_OR;  req0_a = 8'h0F; req0_b = 8'hF0;
        req1_valid = 1; req1_opcode = OP_XOR; req1_a = 8'h0F; req1_b = 8'hF0;
        #1 chk("t6_tie_grant", 32'({req1_ready, req0_ready}), 32'b01);
        step(1);
        req0_valid = 0; req1_valid = 0;
        step(6);

        chk("end_scoreboard_empty", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
